// File: rtl/arbiter_puf_pkg.sv
// Shared types, parameter defaults and sizing helpers for the arbiter PUF chain.
package arbiter_puf_pkg;

    localparam int unsigned DEF_N_STAGES      = 64;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_N_EVAL        = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_LAUNCH,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // Width that holds every count from 0 to n_eval inclusive.
    function automatic int unsigned ones_width(input int unsigned n_eval);
        return $clog2(n_eval + 1);
    endfunction

endpackage

// File: rtl/arbiter_puf_chain_stage.sv
// Delay-chain building blocks: one crossed/straight switch stage and the race arbiter flop.
module puf_stage (
    input  logic i_sel,
    input  logic i_top,
    input  logic i_bot,
    output logic o_top,
    output logic o_bot
);

    // Select 1 swaps the two paths, select 0 passes them straight through.
    assign o_top = i_sel ? i_bot : i_top;
    assign o_bot = i_sel ? i_top : i_bot;

endmodule

module puf_arbiter (
    input  logic i_d,
    input  logic i_clk_path,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    // The bottom path edge samples the top path: 1 means the top edge won the race.
    always_ff @(posedge i_clk_path) begin
        if (i_clr) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/arbiter_puf_chain.sv
// Arbiter PUF: challenge-steered twin delay chain, repeated evaluation and majority vote.
module arbiter_puf_chain
    import arbiter_puf_pkg::*;
#(
    parameter int unsigned N_STAGES      = DEF_N_STAGES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned N_EVAL        = DEF_N_EVAL
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              chal_valid,
    output logic                              chal_ready,
    input  logic [N_STAGES-1:0]               challenge,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic                              response,
    output logic [ones_width(N_EVAL)-1:0]     ones_count,
    output logic                              busy
);

    localparam int unsigned CW = ones_width(N_EVAL);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    state_t              r_state;
    state_t              w_next;
    logic [N_STAGES-1:0] r_chal;
    logic [SW-1:0]       r_settle;
    logic [CW-1:0]       r_eval;
    logic [CW-1:0]       r_ones;
    logic [CW-1:0]       w_eval_inc;
    logic [CW-1:0]       w_ones_inc;
    logic                w_hs;
    logic                w_settle_done;
    logic                r_launch;
    logic                r_arb_clr;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_chal_ready;
    logic                r_busy;
    logic                r_resp_valid;
    logic                r_response;
    logic                w_arb;
    logic                w_top_end;
    logic                w_bot_end;

    assign w_settle_done = (r_settle == SW'(SETTLE_CYCLES - 1));
    assign w_eval_inc    = r_eval + CW'(1);
    assign w_ones_inc    = r_ones + CW'(r_sync2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_hs   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (chal_valid) begin
                    w_hs   = 1'b1;
                    w_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_settle_done) begin
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (w_settle_done) begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_next = (w_eval_inc < CW'(N_EVAL)) ? ST_ARM : ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chal       <= '0;
            r_settle     <= '0;
            r_eval       <= '0;
            r_ones       <= '0;
            r_launch     <= 1'b0;
            r_arb_clr    <= 1'b1;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_chal_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_response   <= 1'b0;
        end else begin
            r_sync1 <= w_arb;
            r_sync2 <= r_sync1;

            if (w_next != r_state) begin
                r_settle <= '0;
            end else if (r_state == ST_ARM || r_state == ST_LAUNCH) begin
                r_settle <= r_settle + SW'(1);
            end

            if (w_hs) begin
                r_chal <= challenge;
                r_ones <= '0;
                r_eval <= '0;
            end else if (r_state == ST_CAPTURE) begin
                r_ones <= w_ones_inc;
                r_eval <= w_eval_inc;
            end

            if (r_state == ST_CAPTURE && w_next == ST_DONE) begin
                r_response <= (w_ones_inc > CW'(N_EVAL / 2));
            end

            r_launch     <= (w_next == ST_LAUNCH);
            r_arb_clr    <= (w_next != ST_LAUNCH);
            r_chal_ready <= (w_next == ST_IDLE);
            r_busy       <= (w_next != ST_IDLE);
            r_resp_valid <= (w_next == ST_DONE);
        end
    end

    // Each stage owns its link nets so the chain is not one self-referencing vector.
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        (* keep = "true", dont_touch = "true" *) logic w_top_in;
        (* keep = "true", dont_touch = "true" *) logic w_bot_in;
        (* keep = "true", dont_touch = "true" *) logic w_top_out;
        (* keep = "true", dont_touch = "true" *) logic w_bot_out;

        if (gi == 0) begin : g_head
            assign w_top_in = r_launch;
            assign w_bot_in = r_launch;
        end else begin : g_link
            assign w_top_in = g_stage[gi-1].w_top_out;
            assign w_bot_in = g_stage[gi-1].w_bot_out;
        end

        puf_stage u_stage (
            .i_sel (r_chal[gi]),
            .i_top (w_top_in),
            .i_bot (w_bot_in),
            .o_top (w_top_out),
            .o_bot (w_bot_out)
        );
    end

    assign w_top_end = g_stage[N_STAGES-1].w_top_out;
    assign w_bot_end = g_stage[N_STAGES-1].w_bot_out;

    puf_arbiter u_arb (
        .i_d        (w_top_end),
        .i_clk_path (w_bot_end),
        .i_clr      (r_arb_clr),
        .o_q        (w_arb)
    );

    assign chal_ready = r_chal_ready;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign response   = r_response;
    assign ones_count = r_ones;

endmodule

// File: doc/arbiter_puf_chain.md
ARBITER_PUF_CHAIN -- requirements
Module: arbiter_puf_chain

Interface
REQ-001 SHALL have parameter N_STAGES, default 64: number of challenge-controlled switch stages in the delay chain; legal range 2..256.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: clock cycles each ARM and LAUNCH phase lasts; legal range 1..255.
REQ-003 SHALL have parameter N_EVAL, default 5: evaluations per challenge for the majority vote; odd, legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port chal_valid, input, 1 bit: a challenge is offered.
REQ-007 SHALL have port chal_ready, output, 1 bit: the block accepts a challenge this cycle.
REQ-008 SHALL have port challenge, input, N_STAGES bits: bit i is the select for stage i (0 = straight, 1 = crossed).
REQ-009 SHALL have port resp_valid, output, 1 bit: the response is available.
REQ-010 SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 SHALL have port response, output, 1 bit: the majority-voted PUF bit.
REQ-012 SHALL have port ones_count, output, clog2(N_EVAL+1) bits: the number of evaluations that returned 1 (reliability metric).
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, ARM, LAUNCH, CAPTURE and DONE.
REQ-015 SHALL drive chal_ready high exactly when the state is IDLE.
REQ-016 SHALL, on the handshake chal_valid && chal_ready at cycle T, latch challenge, clear ones_count and the evaluation counter, and enter ARM at T+1.
REQ-017 SHALL hold ARM for SETTLE_CYCLES cycles with launch=0 and the arbiter clear asserted, so both paths settle low.
REQ-018 SHALL hold LAUNCH for SETTLE_CYCLES cycles with launch=1 driven into both path inputs and the arbiter clear released.
REQ-019 SHALL, in CAPTURE (one cycle), add the arbiter output to ones_count and increment the evaluation counter, then go to ARM if the counter is below N_EVAL, else to DONE.
REQ-020 SHALL in DONE hold resp_valid=1, response=(ones_count > N_EVAL/2) and ones_count stable until resp_ready=1, then return to IDLE on the next cycle.
REQ-021 SHALL raise resp_valid exactly at T + N_EVAL*(2*SETTLE_CYCLES+1) + 1.
REQ-022 SHALL drive the stage selects only from the latched challenge; changes on the challenge input while busy have no effect.
REQ-023 SHALL ignore chal_valid in any non-IDLE state, including DONE and the DONE-to-IDLE transition cycle.
REQ-024 SHALL saturate nothing: ones_count width is sized so that N_EVAL never overflows it.

Reset
REQ-025 SHALL on rst=1 at a rising edge enter IDLE and set resp_valid=0, response=0, ones_count=0, busy=0, launch=0 and arbiter clear=1, regardless of the current state.
REQ-026 SHALL discard any in-flight evaluation on reset mid-operation; no resp_valid pulse is produced for the aborted challenge.

Structure
REQ-027 SHALL place the FSM state enum, the parameter defaults and the ones_count width function in the shared package arbiter_puf_pkg.
REQ-028 SHALL instantiate N_STAGES copies of sub-module puf_stage, each being two 2:1 multiplexers with common select and crossed inputs (top/bottom in, top/bottom out), chained by a generate loop.
REQ-029 SHALL terminate the chain in one arbiter flop instance named u_arb (D = top path, clock = bottom path, synchronous clear from the FSM); its output is double-registered on clk before being sampled in CAPTURE.
REQ-030 SHALL carry a keep/dont-touch attribute on all chain nets so that synthesis cannot merge or optimise away stages.

Verification (the bench forces the u_arb output per evaluation)
REQ-031 With defaults, challenge 0xA5..A5 accepted at T and arbiter forced to 1 for all evaluations -> resp_valid=1 at T+86, response=1, ones_count=5.
REQ-032 With defaults and the forced sequence 1,0,1,0,0 -> response=0, ones_count=2.
REQ-033 With resp_ready held low for 10 cycles in DONE -> resp_valid, response and ones_count stay stable, chal_ready=0, and IDLE is reached one cycle after resp_ready rises.
REQ-034 With rst asserted for 1 cycle during LAUNCH -> launch=0, busy=0, chal_ready=1 on the next cycle, and no resp_valid for that challenge.
REQ-035 With chal_valid pulsed with a different challenge while busy -> it is not accepted and the stage selects keep the original value.
REQ-036 With N_EVAL=1, SETTLE_CYCLES=1 and the arbiter forced to 1 -> resp_valid at T+4, response=1, ones_count=1.
